// File: rtl/lsu_if.sv
// Purpose: bundles the lsu's exu-side, writeback-side and memory-bus signals into one interface.
// Latency: none; this is wiring only.
// Backpressure: carries l_ready_o / l_ready_i / mem_req_ready_i / mem_rsp_ready_o between the ends.
//
// Ports (signal groups):
//   exu -> lsu : l_valid_i, l_ready_o, is_load_i, is_store_i, funct3_i, addr_i, wdata_i, exu_res_i
//   lsu -> wb  : l_valid_o, l_ready_i, res_o, err_o
//   mem req    : mem_req_valid_o, mem_req_ready_i, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
//   mem rsp    : mem_rsp_valid_i, mem_rsp_ready_o, mem_rdata_i
// The slave modport is the lsu's view; master is the surrounding pipeline/memory view.
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  // exu -> lsu
  logic              l_valid_i;
  logic              l_ready_o;
  logic              is_load_i;
  logic              is_store_i;
  logic [2:0]        funct3_i;
  logic [ADDR_W-1:0] addr_i;
  logic [XLEN-1:0]   wdata_i;
  logic [XLEN-1:0]   exu_res_i;
  // lsu -> writeback
  logic              l_valid_o;
  logic              l_ready_i;
  logic [XLEN-1:0]   res_o;
  logic              err_o;
  // memory request
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_wstrb_o;
  // memory response
  logic              mem_rsp_valid_i;
  logic              mem_rsp_ready_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  l_valid_i, is_load_i, is_store_i, funct3_i, addr_i, wdata_i, exu_res_i,
    output l_ready_o,
    output l_valid_o, res_o, err_o,
    input  l_ready_i,
    output mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_req_ready_i,
    input  mem_rsp_valid_i, mem_rdata_i,
    output mem_rsp_ready_o
  );

  modport master (
    output l_valid_i, is_load_i, is_store_i, funct3_i, addr_i, wdata_i, exu_res_i,
    input  l_ready_o,
    input  l_valid_o, res_o, err_o,
    output l_ready_i,
    input  mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_req_ready_i,
    output mem_rsp_valid_i, mem_rdata_i,
    input  mem_rsp_ready_o
  );
endinterface

// File: rtl/lsu.sv
// Purpose: load/store unit; takes one instruction from exu, does at most one word-bus access, hands result to writeback.
// Latency: accept -> l_valid_o is 1 cycle for non-memory/faulting ops, 3 cycles for loads/stores with zero-wait memory.
// Backpressure: one instruction in flight; l_ready_o only in IDLE; request, result and error held until their handshakes.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset (returns to IDLE at any point, abandoning a bus access)
//   bus      : lsu_if.slave carrying the exu, writeback and memory request/response handshakes
module lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;

  // Latched instruction context
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [XLEN-1:0]   res_q;
  logic              err_q;

  // Accept-time decode
  logic              is_mem;
  logic              f3_legal;
  logic              misaligned;
  logic              acc_err;
  logic [1:0]        off_in;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;

  // Response-time formatting
  logic [31:0]       shifted;
  logic [XLEN-1:0]   ld_data;

  assign off_in = bus.addr_i[1:0];

  always_comb begin
    is_mem   = bus.is_load_i | bus.is_store_i;
    f3_legal = 1'b0;
    case (bus.funct3_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
      default:                                f3_legal = 1'b0;
    endcase

    // funct3[1:0] encodes the size for both signed and unsigned forms.
    misaligned = 1'b0;
    case (bus.funct3_i[1:0])
      2'b01:   misaligned = off_in[0];
      2'b10:   misaligned = (off_in != 2'b00);
      default: misaligned = 1'b0;
    endcase

    // funct3 and alignment are only meaningful for memory ops; ALU ops reuse
    // funct3 values such as 011, so they must not be flagged as faults.
    acc_err = (bus.is_load_i & bus.is_store_i) |
              (is_mem & (~f3_legal | misaligned));
  end

  // Store data is replicated across all lanes so the strobe alone selects
  // the target bytes; the memory never has to shift.
  always_comb begin
    st_wdata = bus.wdata_i;
    st_wstrb = 4'b1111;
    case (bus.funct3_i[1:0])
      2'b00: begin
        st_wdata = {4{bus.wdata_i[7:0]}};
        st_wstrb = 4'b0001 << off_in;
      end
      2'b01: begin
        st_wdata = {2{bus.wdata_i[15:0]}};
        st_wstrb = 4'b0011 << off_in;
      end
      default: begin
        st_wdata = bus.wdata_i;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by access type.
  always_comb begin
    shifted = bus.mem_rdata_i >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.l_valid_i) begin
            funct3_q <= bus.funct3_i;
            off_q    <= off_in;
            we_q     <= bus.is_store_i;
            addr_q   <= {bus.addr_i[ADDR_W-1:2], 2'b00};
            wdata_q  <= bus.is_store_i ? st_wdata : 32'd0;
            wstrb_q  <= bus.is_store_i ? st_wstrb : 4'd0;
            if (acc_err) begin
              err_q <= 1'b1;
              res_q <= '0;
              state <= DONE;
            end else if (is_mem) begin
              err_q <= 1'b0;
              res_q <= '0;
              state <= REQ;
            end else begin
              err_q <= 1'b0;
              res_q <= bus.exu_res_i;
              state <= DONE;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready_i) begin
            state <= RSP;
          end
        end
        RSP: begin
          if (bus.mem_rsp_valid_i) begin
            // Store responses are only completion acks; their data is ignored.
            res_q <= we_q ? '0 : ld_data;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.l_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All handshake outputs are pure state decodes: no ready-to-valid paths.
  assign bus.l_ready_o       = (state == IDLE);
  assign bus.mem_req_valid_o = (state == REQ);
  assign bus.mem_rsp_ready_o = (state == RSP);
  assign bus.l_valid_o       = (state == DONE);

  // Request fields read as zero whenever no request is being offered.
  assign bus.mem_we_o    = (state == REQ) ? we_q    : 1'b0;
  assign bus.mem_addr_o  = (state == REQ) ? addr_q  : '0;
  assign bus.mem_wdata_o = (state == REQ) ? wdata_q : 32'd0;
  assign bus.mem_wstrb_o = (state == REQ) ? wstrb_q : 4'd0;

  assign bus.res_o = res_q;
  assign bus.err_o = err_q;

endmodule

// File: tb/tb_lsu.sv
// Purpose: self-checking bench for lsu; directed cases plus randomized ops against a behavioural model.
// Latency: checks 1-cycle non-memory and 3-cycle zero-wait memory completion.
// Backpressure: exercises stalls on request ready, response valid and writeback ready.
module tb_lsu;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

  logic [31:0] got_res;
  logic        got_err;

  lsu_if #(.XLEN(32), .ADDR_W(32)) bus ();

  lsu #(.XLEN(32), .ADDR_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expectations derived from size/offset arithmetic.
  task automatic model(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exu, input logic [31:0] rdata,
                       output logic mem, output logic err, output logic we,
                       output logic [31:0] maddr, output logic [31:0] mwdata,
                       output logic [3:0] strb, output logic [31:0] res);
    int     nb;
    int     o;
    bit     legal;
    longint span;
    longint v;
    legal  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    nb     = 1 << int'(f3 % 3'd4);
    o      = int'(addr % 32'd4);
    mem    = ld || st;
    err    = (ld && st) || (mem && (!legal || (int'(addr % 32'd8) % nb) != 0));
    we     = st;
    maddr  = addr - 32'(o);
    mwdata = 32'd0;
    strb   = 4'd0;
    res    = 32'd0;
    if (!mem) begin
      res = exu;
    end else if (!err) begin
      span = longint'(1) << (8 * nb);
      if (st) begin
        v = longint'(wdata) % span;
        if (nb == 4)      mwdata = wdata;
        else if (nb == 2) mwdata = 32'(v * 65537);
        else              mwdata = 32'(v * 16843009);
        strb = 4'(((1 << nb) - 1) << o);
      end else begin
        v = (longint'(rdata) >> (8 * o)) % span;
        if (f3 < 3'd4 && nb < 4 && v >= span / 2) v = v - span;
        res = 32'(v);
      end
    end
  endtask

  task automatic check_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    check("req_vld",  32'(bus.mem_req_valid_o), 32'd1);
    check("req_we",   32'(bus.mem_we_o),        32'(we));
    check("req_addr", bus.mem_addr_o,           addr);
    check("req_strb", 32'(bus.mem_wstrb_o),     32'(strb));
    if (we) check("req_wdata", bus.mem_wdata_o, wdata);
    check("req_lrdy", 32'(bus.l_ready_o),       32'd0);
  endtask

  task automatic scramble();
    bus.is_load_i  = 1'($urandom);
    bus.is_store_i = 1'($urandom);
    bus.funct3_i   = 3'($urandom);
    bus.addr_i     = $urandom;
    bus.wdata_i    = $urandom;
    bus.exu_res_i  = $urandom;
  endtask

  // One full instruction from accept to writeback handshake; called at posedge+1 in IDLE.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exu, input logic [31:0] rdata,
                        input int req_wait, input int rsp_wait, input int wb_wait,
                        output logic [31:0] o_res, output logic o_err);
    logic e_mem, e_err, e_we;
    logic [31:0] e_addr, e_wdata, e_res;
    logic [3:0]  e_strb;
    model(ld, st, f3, addr, wdata, exu, rdata, e_mem, e_err, e_we, e_addr, e_wdata, e_strb, e_res);
    o_res = 32'd0;
    o_err = 1'b0;

    check("acc_lrdy", 32'(bus.l_ready_o), 32'd1);
    bus.l_valid_i  = 1'b1;
    bus.is_load_i  = ld;
    bus.is_store_i = st;
    bus.funct3_i   = f3;
    bus.addr_i     = addr;
    bus.wdata_i    = wdata;
    bus.exu_res_i  = exu;
    step();
    bus.l_valid_i = 1'b0;
    scramble();

    if (e_mem && !e_err) begin
      check("req_early_vld", 32'(bus.l_valid_o), 32'd0);
      for (int i = 0; i < req_wait; i++) begin
        check_req(e_we, e_addr, e_wdata, e_strb);
        step();
      end
      check_req(e_we, e_addr, e_wdata, e_strb);
      bus.mem_req_ready_i = 1'b1;
      step();
      bus.mem_req_ready_i = 1'b0;
      check("rsp_noreq", 32'(bus.mem_req_valid_o), 32'd0);
      for (int i = 0; i < rsp_wait; i++) begin
        check("rsp_rdy", 32'(bus.mem_rsp_ready_o), 32'd1);
        check("rsp_early_vld", 32'(bus.l_valid_o), 32'd0);
        step();
      end
      check("rsp_rdy", 32'(bus.mem_rsp_ready_o), 32'd1);
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = rdata;
      step();
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rdata_i     = $urandom;
    end

    for (int i = 0; i <= wb_wait; i++) begin
      check("wb_vld",   32'(bus.l_valid_o),       32'd1);
      check("wb_res",   bus.res_o,                e_res);
      check("wb_err",   32'(bus.err_o),           32'(e_err));
      check("wb_lrdy",  32'(bus.l_ready_o),       32'd0);
      check("wb_noreq", 32'(bus.mem_req_valid_o), 32'd0);
      o_res = bus.res_o;
      o_err = bus.err_o;
      if (i == wb_wait) bus.l_ready_i = 1'b1;
      step();
    end
    bus.l_ready_i = 1'b0;
    check("idle_lrdy", 32'(bus.l_ready_o), 32'd1);
    check("idle_vld",  32'(bus.l_valid_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lrdy"},   32'(bus.l_ready_o),       32'd1);
    check({tag, "_vld"},    32'(bus.l_valid_o),       32'd0);
    check({tag, "_reqv"},   32'(bus.mem_req_valid_o), 32'd0);
    check({tag, "_rsprdy"}, 32'(bus.mem_rsp_ready_o), 32'd0);
    check({tag, "_res"},    bus.res_o,                32'd0);
    check({tag, "_err"},    32'(bus.err_o),           32'd0);
    check({tag, "_we"},     32'(bus.mem_we_o),        32'd0);
    check({tag, "_addr"},   bus.mem_addr_o,           32'd0);
    check({tag, "_strb"},   32'(bus.mem_wstrb_o),     32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic        ld, st;
    int          kind;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.l_valid_i       = 1'b0;
    bus.l_ready_i       = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rdata_i     = 32'd0;
    scramble();
    step();
    step();
    check_reset_outputs("rst");
    rst = 1'b0;
    step();

    // Non-memory pass-through
    run_op(1'b0, 1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h1234_5678, 32'h0, 0, 0, 0, got_res, got_err);
    check("alu_res", got_res, 32'h1234_5678);

    // LB / LBU at byte 3
    run_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h0, 32'h80AA_BBCC, 0, 0, 0, got_res, got_err);
    check("lb_res", got_res, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h0, 32'h80AA_BBCC, 0, 0, 0, got_res, got_err);
    check("lbu_res", got_res, 32'h0000_0080);

    // SH to upper half: replicated data, strobes 1100
    run_op(1'b0, 1'b1, 3'b001, 32'h8000_0102, 32'hDEAD_BEEF, 32'h0, 32'h5555_5555, 0, 0, 0, got_res, got_err);
    check("sh_res", got_res, 32'h0);

    // Misaligned LW: error, no memory traffic
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0006, 32'h0, 32'h0, 32'h0, 0, 0, 0, got_res, got_err);
    check("lw_mis_err", 32'(got_err), 32'd1);
    check("lw_mis_res", got_res, 32'h0);

    // Backpressure on every handshake
    run_op(1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'hA5A5_0F0F, 32'h0, 32'h0, 5, 3, 4, got_res, got_err);
    run_op(1'b1, 1'b0, 3'b101, 32'h8000_0012, 32'h0, 32'h0, 32'h9876_5432, 5, 3, 4, got_res, got_err);
    check("lhu_bp_res", got_res, 32'h0000_9876);

    // Reset while waiting for a response
    bus.l_valid_i  = 1'b1;
    bus.is_load_i  = 1'b1;
    bus.is_store_i = 1'b0;
    bus.funct3_i   = 3'b010;
    bus.addr_i     = 32'h8000_0020;
    step();
    bus.l_valid_i       = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    step();
    bus.mem_req_ready_i = 1'b0;
    check("pre_rst_rsprdy", 32'(bus.mem_rsp_ready_o), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    #2;
    rst = 1'b0;
    step();
    check_reset_outputs("postrst");
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 0, 0, got_res, got_err);
    check("lw_after_rst", got_res, 32'hCAFE_F00D);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      ld   = (kind <= 3) || (kind == 9);
      st   = (kind >= 4 && kind <= 6) || (kind == 9);
      case ($urandom_range(0, 5))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        4: f3 = 3'b101;
        default: f3 = 3'($urandom);
      endcase
      // Non-memory ops keep a plain word-sized, aligned encoding.
      if (!ld && !st) f3 = 3'b010;
      run_op(ld, st, f3,
             (!ld && !st) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
             $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             got_res, got_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit: downstream end of the execute-stage valid/ready handshake. Accepts one instruction at a time from exu, performs at most one memory access, and hands the result to writeback through a second valid/ready pair.
- Memory side is a simple request/response bus, 32-bit word-addressed with byte strobes.
- Handles byte-lane alignment, store-data replication, load sign/zero extension and misalignment detection.
- Instructions that are neither load nor store pass through with their exu result.

Parameters:
- XLEN, 32, data/register width (only 32 supported).
- ADDR_W, 32, memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- l_valid_i  in  1  instruction valid from exu
- l_ready_o  out  1  lsu can accept from exu
- is_load_i  in  1  instruction is a load
- is_store_i  in  1  instruction is a store
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  ADDR_W  effective address (exu result)
- wdata_i  in  XLEN  store data (src2)
- exu_res_i  in  XLEN  exu result for non-memory instructions
- l_valid_o  out  1  result valid to writeback
- l_ready_i  in  1  writeback accepts
- res_o  out  XLEN  load data, exu result, or 0 (store/error)
- err_o  out  1  misaligned/illegal access; qualified by l_valid_o
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_W  word-aligned address (addr & ~3)
- mem_wdata_o  out  32  lane-replicated store data
- mem_wstrb_o  out  4  byte strobes (0 on reads)
- mem_rsp_valid_i  in  1  response valid
- mem_rsp_ready_o  out  1  lsu accepts response
- mem_rdata_i  in  32  read data word

Behaviour:
- FSM states: IDLE, REQ, RSP, DONE. Reset (async, any time including mid-access) forces IDLE. At reset: all valid/ready outputs 0 except l_ready_o=1; res_o=0, err_o=0, mem_* outputs 0. An abandoned memory request is dropped; the bus tolerates this.
- IDLE:
  - l_ready_o=1.
  - On l_valid_i, latch all inputs.
  - Error case: illegal funct3 (011, 11x), is_load_i and is_store_i both set, halfword with addr[0]=1, or word with addr[1:0]!=0. Then set err, res=0, go to DONE. No memory traffic.
  - Load or store otherwise goes to REQ.
  - Neither load nor store: res=exu_res_i, go to DONE.
- REQ:
  - mem_req_valid_o=1. Address, we, wdata and wstrb are held stable until mem_req_ready_i.
  - On handshake, go to RSP.
- RSP:
  - mem_rsp_ready_o=1.
  - On mem_rsp_valid_i, go to DONE. Loads capture formatted data; stores set res=0 and ignore rdata.
  - A response may arrive in the cycle after the request handshake, at the earliest.
- DONE:
  - l_valid_o=1. res_o and err_o are held stable until l_ready_i, then return to IDLE.
  - l_ready_o=0 in DONE; no same-cycle re-accept.
- Minimum latency, accept to l_valid_o:
  - non-memory: 1 cycle
  - memory: 3 cycles with zero-wait memory
- Store formatting, with o = addr[1:0]:
  - B: wdata = {4{wdata[7:0]}}, wstrb = 4'b0001<<o
  - H: wdata = {2{wdata[15:0]}}, wstrb = 4'b0011<<o
  - W: wdata unchanged, wstrb = 4'b1111
- Load formatting: shifted = rdata >> (8*o). B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
- l_ready_o and mem_req_valid_o depend only on state, with no combinational path from ready inputs.

Test Plan:
- Non-memory op: exu_res_i=0x1234_5678, l_ready_i=1 -> l_valid_o one cycle after accept, res_o=0x1234_5678, err_o=0, no mem_req_valid_o.
- LB at addr 0x8000_0003, rdata 0x80AA_BBCC -> mem_addr_o=0x8000_0000, wstrb=0, res_o=0xFFFF_FF80. Same access as LBU gives 0x0000_0080.
- SH at addr 0x8000_0102, wdata 0xDEAD_BEEF -> mem_wdata_o=0xBEEF_BEEF, wstrb=4'b1100, we=1; res_o=0.
- LW at addr 0x8000_0006 -> err_o=1, res_o=0, mem_req_valid_o never asserted.
- Backpressure: mem_req_ready_i low 5 cycles, mem_rsp_valid_i delayed 3 cycles, l_ready_i low 4 cycles. Required: request fields and res_o stable throughout, l_ready_o=0 until the DONE handshake.
- Reset asserted while in RSP -> next state IDLE, all valids 0, l_ready_o=1. Subsequent LW at 0x8000_0000 completes normally.
